sensor_event_scheduler: RTL and testbench

//  Event front-end for the robot's discrete sensor inputs (limit/fall switches).

---
 rtl/sensor_event_pkg.sv | 46 ++++
 rtl/sensor_event_scheduler_debounce.sv | 54 +++++
 rtl/sensor_event_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_sensor_event_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sensor_event_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sensor_event_pkg
// Brief   : Register map, bit positions and event record for the sensor
//           event scheduler.
// Revision: 1.0 - initial release
// ============================================================================
package sensor_event_pkg;

    localparam logic [1:0] c_addr_status   = 2'd0;
    localparam logic [1:0] c_addr_event    = 2'd1;
    localparam logic [1:0] c_addr_ctrl     = 2'd2;
    localparam logic [1:0] c_addr_debounce = 2'd3;

    localparam int c_status_empty_bit = 0;
    localparam int c_status_full_bit  = 1;
    localparam int c_status_ovf_bit   = 2;
    localparam int c_status_count_lsb = 8;

    localparam int c_ctrl_irq_en_bit  = 16;
    localparam int c_ctrl_fall_en_bit = 17;
    localparam int c_ctrl_rise_en_bit = 18;

    localparam int c_evt_valid_bit = 31;
    localparam int c_evt_rise_bit  = 30;
    localparam int c_evt_ch_lsb    = 24;
    localparam int c_evt_ts_max    = 24;

    typedef struct packed {
        logic                    is_rise;
        logic [3:0]              ch;
        logic [c_evt_ts_max-1:0] ts;
    } event_t;

    function automatic logic [31:0] event_word(input event_t e);
        logic [31:0] w;
        w                          = '0;
        w[c_evt_valid_bit]         = 1'b1;
        w[c_evt_rise_bit]          = e.is_rise;
        w[c_evt_ch_lsb +: 4]       = e.ch;
        w[c_evt_ts_max-1:0]        = e.ts;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_event_scheduler_debounce.sv
`default_nettype none
// ============================================================================
// Module  : sensor_debounce
// Brief   : 2-flop synchroniser plus stable-count debouncer; emits one-cycle
//           registered rise/fall pulses when a new level is accepted.
// Revision: 1.0 - initial release
// ============================================================================
module sensor_debounce #(
    parameter int DB_WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                async_i,
    input  logic [DB_WIDTH-1:0] db_limit_i,
    output logic                rise_o,
    output logic                fall_o
);

    logic                sync1_q;
    logic                sync2_q;
    logic                level_q;
    logic [DB_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
            if (sync2_q != level_q) begin
                // >= so that lowering the limit mid-count still accepts promptly
                if (cnt_q >= db_limit_i) begin
                    level_q <= sync2_q;
                    cnt_q   <= '0;
                    rise_o  <= sync2_q;
                    fall_o  <= ~sync2_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sensor_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : sensor_event_scheduler
// Brief   : Debounced edge capture, round-robin timestamping into an event
//           FIFO, Avalon-MM CSR access and level interrupt.
// Revision: 1.0 - initial release
// ============================================================================
module sensor_event_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int TS_WIDTH   = 24,
    parameter int DB_WIDTH   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] in_port,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);
    import sensor_event_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [NUM_CH-1:0]   w_rise, w_fall, w_evt, w_ch_en_d, w_grant_vec;
    logic [NUM_CH-1:0]   ch_en_q, pending_q, pend_rise_q;
    logic [TS_WIDTH-1:0] pend_ts_q [NUM_CH];
    logic [TS_WIDTH-1:0] ts_q;
    logic [DB_WIDTH-1:0] db_limit_q;
    logic                irq_en_q, fall_en_q, rise_en_q, ovf_q;
    logic [3:0]          rr_ptr_q, w_win;
    logic [4:0]          w_idx, w_nxt_ptr;
    logic [15:0]         w_pend16;
    logic                w_grant, w_pop, w_empty, w_full, w_ovf_hit;
    logic                w_wr, w_rd;
    event_t              fifo_q [FIFO_DEPTH];
    event_t              w_push_evt;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic [31:0]         w_rdata;
    logic                w_unused;

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            sensor_debounce #(.DB_WIDTH(DB_WIDTH)) u_db (
                .clk        (clk),
                .reset      (reset),
                .async_i    (in_port[g]),
                .db_limit_i (db_limit_q),
                .rise_o     (w_rise[g]),
                .fall_o     (w_fall[g])
            );
        end
    endgenerate

    assign w_wr      = chipselect & ~write_n;
    assign w_rd      = chipselect & ~read_n;
    assign w_empty   = (count_q == '0);
    assign w_full    = (count_q == CW'(FIFO_DEPTH));
    assign w_pop     = w_rd && (address == c_addr_event) && !w_empty;
    assign w_ch_en_d = (w_wr && address == c_addr_ctrl) ? writedata[NUM_CH-1:0] : ch_en_q;
    assign w_evt     = ch_en_q & ((w_rise & {NUM_CH{rise_en_q}}) | (w_fall & {NUM_CH{fall_en_q}}));
    assign w_ovf_hit = |(w_evt & pending_q & ~w_grant_vec & w_ch_en_d);
    assign w_unused  = ^{writedata, w_nxt_ptr[4]};

    // Round-robin search starting at rr_ptr_q; no grant while the FIFO is full
    always_comb begin
        w_pend16 = 16'(pending_q);
        w_grant  = 1'b0;
        w_win    = '0;
        w_idx    = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            w_idx = {1'b0, rr_ptr_q} + 5'(off);
            if (w_idx >= 5'(NUM_CH)) w_idx = w_idx - 5'(NUM_CH);
            if (!w_grant && !w_full && w_pend16[w_idx[3:0]]) begin
                w_grant = 1'b1;
                w_win   = w_idx[3:0];
            end
        end
        w_nxt_ptr = {1'b0, w_win} + 5'd1;
        if (w_nxt_ptr == 5'(NUM_CH)) w_nxt_ptr = '0;
    end

    always_comb begin
        w_grant_vec = '0;
        w_push_evt  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_grant && w_win == 4'(i)) begin
                w_grant_vec[i]               = 1'b1;
                w_push_evt.is_rise           = pend_rise_q[i];
                w_push_evt.ch                = 4'(i);
                w_push_evt.ts[TS_WIDTH-1:0]  = pend_ts_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q   <= '0;
            pend_rise_q <= '0;
            rr_ptr_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) pend_ts_q[i] <= '0;
        end else begin
            if (w_grant) rr_ptr_q <= w_nxt_ptr[3:0];
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_ch_en_d[i]) begin
                    pending_q[i] <= 1'b0;
                end else if (w_evt[i] && (!pending_q[i] || w_grant_vec[i])) begin
                    pending_q[i]   <= 1'b1;
                    pend_rise_q[i] <= w_rise[i];
                    pend_ts_q[i]   <= ts_q;
                end else if (w_grant_vec[i]) begin
                    pending_q[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) fifo_q[wr_ptr_q] <= w_push_evt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_grant) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({w_grant, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (address)
            c_addr_status: begin
                w_rdata[c_status_empty_bit]        = w_empty;
                w_rdata[c_status_full_bit]         = w_full;
                w_rdata[c_status_ovf_bit]          = ovf_q;
                w_rdata[c_status_count_lsb +: 5]   = 5'(count_q);
            end
            c_addr_event: begin
                if (!w_empty) w_rdata = event_word(fifo_q[rd_ptr_q]);
            end
            c_addr_ctrl: begin
                w_rdata[NUM_CH-1:0]         = ch_en_q;
                w_rdata[c_ctrl_irq_en_bit]  = irq_en_q;
                w_rdata[c_ctrl_fall_en_bit] = fall_en_q;
                w_rdata[c_ctrl_rise_en_bit] = rise_en_q;
            end
            default: w_rdata[DB_WIDTH-1:0] = db_limit_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch_en_q    <= '0;
            irq_en_q   <= 1'b0;
            fall_en_q  <= 1'b0;
            rise_en_q  <= 1'b0;
            db_limit_q <= '0;
            ovf_q      <= 1'b0;
            ts_q       <= '0;
            readdata   <= '0;
            irq        <= 1'b0;
        end else begin
            ts_q     <= ts_q + 1'b1;
            irq      <= irq_en_q & ~w_empty;
            readdata <= w_rd ? w_rdata : '0;
            ch_en_q  <= w_ch_en_d;
            if (w_wr && address == c_addr_ctrl) begin
                irq_en_q  <= writedata[c_ctrl_irq_en_bit];
                fall_en_q <= writedata[c_ctrl_fall_en_bit];
                rise_en_q <= writedata[c_ctrl_rise_en_bit];
            end
            if (w_wr && address == c_addr_debounce) db_limit_q <= writedata[DB_WIDTH-1:0];
            if (w_ovf_hit) begin
                ovf_q <= 1'b1;
            end else if (w_wr && address == c_addr_status && writedata[c_status_ovf_bit]) begin
                ovf_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sensor_event_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_sensor_event_scheduler
// Brief   : Directed and randomised self-checking bench for the scheduler.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sensor_event_scheduler;

    localparam int TSW = 10;
    localparam logic [31:0] EV_MASK = 32'hFFFF_FC00;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  in_port;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [31:0] writedata, readdata;
    logic        irq;
    logic [TSW-1:0] ts_m;

    int n_checks = 0;
    int n_fail   = 0;

    sensor_event_scheduler #(.NUM_CH(4), .FIFO_DEPTH(16), .TS_WIDTH(TSW), .DB_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .in_port(in_port), .address(address),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Free-running timestamp as seen by the host: zero in reset, +1 per clock
    always @(posedge clk) begin
        if (reset) ts_m <= '0;
        else       ts_m <= ts_m + 1'b1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    function automatic logic [31:0] exp_word(input bit r, input int ch, input logic [TSW-1:0] ts);
        return {1'b1, r, 2'b00, 4'(ch), 14'b0, ts};
    endfunction

    logic [31:0]    rd, ctl;
    logic [TSW-1:0] v0, target;
    logic [31:0]    q[$];
    int             d, ch, len;
    bit             ren, fen, r;

    initial begin
        reset = 1'b1; in_port = '0; address = '0; chipselect = 1'b0;
        read_n = 1'b1; write_n = 1'b1; writedata = '0;
        tick(3);
        check_eq("rst_readdata", readdata, 32'h0);
        check_eq("rst_irq", {31'b0, irq}, 32'h0);
        reset = 1'b0;
        tick(1);
        csr_read(2'd0, rd); check_eq("rst_status", rd, 32'h1);
        csr_read(2'd2, rd); check_eq("rst_ctrl", rd, 32'h0);

        // 1: single rising edge, exact latency and timestamp
        csr_write(2'd3, 32'd3);
        csr_write(2'd2, 32'h0005_0001);
        csr_read(2'd2, rd); check_eq("ctrl_rb", rd, 32'h0005_0001);
        in_port[0] = 1'b1; v0 = ts_m;
        tick(8);
        check_eq("t1_irq_early", {31'b0, irq}, 32'h0);
        tick(1);
        check_eq("t1_irq_set", {31'b0, irq}, 32'h1);
        csr_read(2'd1, rd); check_eq("t1_event", rd, exp_word(1'b1, 0, v0 + TSW'(6)));
        csr_read(2'd0, rd); check_eq("t1_empty", rd, 32'h1);
        check_eq("t1_irq_clr", {31'b0, irq}, 32'h0);

        // 2: glitch rejected, held level accepted once
        csr_write(2'd3, 32'd5);
        csr_write(2'd2, 32'h0005_0002);
        in_port[1] = 1'b1; tick(4); in_port[1] = 1'b0;
        tick(15);
        csr_read(2'd0, rd); check_eq("t2_glitch", rd, 32'h1);
        in_port[1] = 1'b1; tick(20);
        csr_read(2'd0, rd); check_eq("t2_count", rd, 32'h100);
        csr_read(2'd1, rd); check_eq("t2_event", rd & EV_MASK, 32'hC100_0000);

        // 3: simultaneous edges on all channels after reset
        in_port = '0; tick(10);
        reset = 1'b1; tick(2); reset = 1'b0; tick(1);
        csr_write(2'd3, 32'd2);
        csr_write(2'd2, 32'h0005_000F);
        in_port = 4'hF; v0 = ts_m;
        tick(20);
        csr_read(2'd0, rd); check_eq("t3_count", rd, 32'h400);
        for (int k = 0; k < 4; k++) begin
            csr_read(2'd1, rd);
            check_eq($sformatf("t3_ev%0d", k), rd, exp_word(1'b1, k, v0 + TSW'(5)));
        end

        // 4: full FIFO holds pending edge, second edge overflows
        csr_write(2'd2, 32'h0007_000F);
        for (int k = 0; k < 16; k++) begin
            in_port[0] = ~in_port[0]; tick(10);
        end
        csr_read(2'd0, rd); check_eq("t4_full", rd, 32'h1002);
        in_port[2] = 1'b0; tick(10);
        csr_read(2'd0, rd); check_eq("t4_pend", rd, 32'h1002);
        in_port[2] = 1'b1; tick(10);
        csr_read(2'd0, rd); check_eq("t4_ovf", rd, 32'h1006);
        csr_read(2'd1, rd); check_eq("t4_pop0", rd & EV_MASK, 32'h8000_0000);
        tick(3);
        csr_read(2'd0, rd); check_eq("t4_refill", rd, 32'h1006);
        csr_write(2'd0, 32'h4);
        csr_read(2'd0, rd); check_eq("t4_ovf_clr", rd, 32'h1002);
        for (int k = 1; k < 16; k++) begin
            csr_read(2'd1, rd);
            check_eq($sformatf("t4_drain%0d", k), rd & EV_MASK,
                     (k % 2 == 1) ? 32'hC000_0000 : 32'h8000_0000);
        end
        csr_read(2'd1, rd); check_eq("t4_ch2", rd & EV_MASK, 32'h8200_0000);
        csr_read(2'd0, rd); check_eq("t4_empty", rd, 32'h1);

        // 5: empty read, simultaneous push/pop, timestamp wrap
        csr_read(2'd1, rd); check_eq("t5_empty_rd", rd, 32'h0);
        csr_read(2'd0, rd); check_eq("t5_empty_st", rd, 32'h1);
        in_port[3] = 1'b0; tick(10);
        in_port[1] = 1'b0; tick(6);
        csr_read(2'd1, rd); check_eq("t5_pp_pop", rd & EV_MASK, 32'h8300_0000);
        csr_read(2'd0, rd); check_eq("t5_pp_count", rd, 32'h100);
        csr_read(2'd1, rd); check_eq("t5_pp_new", rd & EV_MASK, 32'h8100_0000);
        target = TSW'(1024 - 5);
        for (int k = 0; k < 2048 && ts_m != target; k++) tick(1);
        check_eq("t5_ts_align", 32'(ts_m), 32'(target));
        in_port[0] = 1'b0; tick(10);
        csr_read(2'd1, rd); check_eq("t5_wrap", rd, 32'h8000_0000);

        // Random edges and glitches against a queue of expected events
        d   = $urandom_range(0, 5);
        ren = 1'($urandom_range(0, 1));
        fen = 1'($urandom_range(0, 1));
        ctl = 32'h0001_000F | (32'(fen) << 17) | (32'(ren) << 18);
        csr_write(2'd3, 32'(d));
        csr_write(2'd2, ctl);
        for (int it = 0; it < 12; it++) begin
            ch = $urandom_range(0, 3);
            if (d > 0 && $urandom_range(0, 2) == 0) begin
                len = $urandom_range(1, d);
                in_port[ch] = ~in_port[ch]; tick(len);
                in_port[ch] = ~in_port[ch]; tick(d + 8);
            end else begin
                r = ~in_port[ch];
                in_port[ch] = r;
                if ((r && ren) || (!r && fen)) q.push_back(exp_word(r, ch, ts_m + TSW'(d + 3)));
                tick(d + 8);
            end
        end
        csr_read(2'd0, rd);
        check_eq("rnd_status", rd, (32'(q.size()) << 8) | ((q.size() == 0) ? 32'h1 : 32'h0));
        while (q.size() > 0) begin
            csr_read(2'd1, rd);
            check_eq("rnd_event", rd, q.pop_front());
        end

        // 6: reset with queued events and a read in flight
        csr_write(2'd3, 32'd2);
        csr_write(2'd2, 32'h0007_000F);
        for (int k = 0; k < 5; k++) begin
            in_port[k % 4] = ~in_port[k % 4]; tick(10);
        end
        csr_read(2'd0, rd); check_eq("t6_count", rd, 32'h500);
        check_eq("t6_irq_on", {31'b0, irq}, 32'h1);
        reset = 1'b1; chipselect = 1'b1; read_n = 1'b0; address = 2'd2;
        @(negedge clk);
        check_eq("t6_irq_rst", {31'b0, irq}, 32'h0);
        check_eq("t6_rd_rst", readdata, 32'h0);
        chipselect = 1'b0; read_n = 1'b1;
        tick(1); reset = 1'b0; tick(1);
        csr_read(2'd0, rd); check_eq("t6_status", rd, 32'h1);
        csr_read(2'd2, rd); check_eq("t6_ctrl", rd, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
